firebird7_in_gate1_tessent_data_mux_nsrc_sync: RTL and testbench

FIREBIRD7_IN_GATE1_TESSENT_DATA_MUX_NSRC_SYNC -- requirements
Module: firebird7_in_gate1_tessent_data_mux_nsrc_sync

---
 rtl/firebird7_in_gate1_tessent_data_mux_nsrc_sync.sv | 130 +++++++++++++
 tb/tb_firebird7_in_gate1_tessent_data_mux_nsrc_sync.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/firebird7_in_gate1_tessent_data_mux_nsrc_sync.sv
// Glitch-safe IJTAG/functional data mux: every source switchover drives SAFE_VALUE for
// SETTLE cycles before the new source appears on the registered output.
module firebird7_in_gate1_tessent_data_mux_nsrc_sync #(
  parameter int unsigned      WIDTH      = 19,
  parameter int unsigned      NUM_SRC    = 4,
  parameter int unsigned      SETTLE     = 2,
  parameter logic [WIDTH-1:0] SAFE_VALUE = '0,
  localparam int unsigned     SEL_W      = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
) (
  input  logic                         ijtag_tck,
  input  logic                         ijtag_reset,
  input  logic [SEL_W-1:0]             ijtag_select,
  input  logic [WIDTH-1:0]             functional_data_in,
  input  logic [(NUM_SRC-1)*WIDTH-1:0] ijtag_data_in,
  input  logic                         capture_en,
  output logic [WIDTH-1:0]             data_out,
  output logic [SEL_W-1:0]             active_sel,
  output logic                         switching,
  output logic                         sel_err,
  output logic [WIDTH-1:0]             capture_data
);

  localparam int unsigned      CNT_W      = $clog2(SETTLE + 1);
  localparam int unsigned      NUM_SLOT   = 1 << SEL_W;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE - 1);

  typedef enum logic {StSteady, StSettle} state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   active_q, active_d;
  logic [SEL_W-1:0]   pending_q, pending_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               switching_q, switching_d;
  logic               sel_err_q, sel_err_d;
  logic [WIDTH-1:0]   capture_q, capture_d;

  // Pad the source table to a full power of two so any select value indexes safely.
  logic [WIDTH-1:0]   src [NUM_SLOT];
  logic               sel_ok;

  assign src[0] = functional_data_in;

  for (genvar n = 1; n < NUM_SRC; n++) begin : g_src
    assign src[n] = ijtag_data_in[(n-1)*WIDTH +: WIDTH];
  end

  for (genvar n = NUM_SRC; n < NUM_SLOT; n++) begin : g_pad
    assign src[n] = SAFE_VALUE;
  end

  assign sel_ok = (32'(ijtag_select) < NUM_SRC);

  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    pending_d   = pending_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    switching_d = switching_q;
    sel_err_d   = sel_err_q | ~sel_ok;
    capture_d   = capture_en ? functional_data_in : capture_q;

    unique case (state_q)
      StSteady: begin
        if (sel_ok && (ijtag_select != active_q)) begin
          state_d     = StSettle;
          pending_d   = ijtag_select;
          cnt_d       = CNT_RELOAD;
          data_d      = SAFE_VALUE;
          switching_d = 1'b1;
        end else begin
          data_d      = src[active_q];
        end
      end
      StSettle: begin
        // A fresh in-range request restarts the safe window, even if it names active_sel.
        if (sel_ok && (ijtag_select != pending_q)) begin
          pending_d   = ijtag_select;
          cnt_d       = CNT_RELOAD;
          data_d      = SAFE_VALUE;
          switching_d = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d       = cnt_q - CNT_W'(1);
          data_d      = SAFE_VALUE;
          switching_d = 1'b1;
        end else begin
          state_d     = StSteady;
          active_d    = pending_q;
          data_d      = src[pending_q];
          switching_d = 1'b0;
        end
      end
      default: begin
        state_d     = StSteady;
        data_d      = SAFE_VALUE;
        switching_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      state_q     <= StSteady;
      active_q    <= '0;
      pending_q   <= '0;
      cnt_q       <= '0;
      data_q      <= SAFE_VALUE;
      switching_q <= 1'b0;
      sel_err_q   <= 1'b0;
      capture_q   <= '0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      switching_q <= switching_d;
      sel_err_q   <= sel_err_d;
      capture_q   <= capture_d;
    end
  end

  assign data_out     = data_q;
  assign active_sel   = active_q;
  assign switching    = switching_q;
  assign sel_err      = sel_err_q;
  assign capture_data = capture_q;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_nsrc_sync.sv
// Bench for the safe-switchover data mux: a 4-source and a 3-source instance share data
// inputs and are checked by directed scenarios plus a randomized run against a queue-free model.
module tb_firebird7_in_gate1_tessent_data_mux_nsrc_sync;

  localparam int W      = 19;
  localparam int SETTLE = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [1:0]     sel0 = '0;
  logic [1:0]     sel3 = '0;
  logic [W-1:0]   func = '0;
  logic [3*W-1:0] ijd = '0;
  logic           cap_en = 1'b0;

  logic [W-1:0] d_out, cap, d3_out, cap3;
  logic [1:0]   act, act3;
  logic         sw, err, sw3, err3;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state per instance: 0 = four sources, 1 = three sources.
  int           m_act [2];
  int           m_tgt [2];
  int           m_done[2];
  logic [W-1:0] m_out [2];
  bit           m_err [2];
  logic [W-1:0] m_cap;

  firebird7_in_gate1_tessent_data_mux_nsrc_sync dut (
    .ijtag_tck          (clk),
    .ijtag_reset        (rst_n),
    .ijtag_select       (sel0),
    .functional_data_in (func),
    .ijtag_data_in      (ijd),
    .capture_en         (cap_en),
    .data_out           (d_out),
    .active_sel         (act),
    .switching          (sw),
    .sel_err            (err),
    .capture_data       (cap)
  );

  firebird7_in_gate1_tessent_data_mux_nsrc_sync #(.NUM_SRC(3)) dut3 (
    .ijtag_tck          (clk),
    .ijtag_reset        (rst_n),
    .ijtag_select       (sel3),
    .functional_data_in (func),
    .ijtag_data_in      (ijd[2*W-1:0]),
    .capture_en         (cap_en),
    .data_out           (d3_out),
    .active_sel         (act3),
    .switching          (sw3),
    .sel_err            (err3),
    .capture_data       (cap3)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] src_val(int idx);
    if (idx == 0) return func;
    return ijd[idx*W-1 -: W];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_act[d]  = 0;
      m_tgt[d]  = -1;
      m_done[d] = 0;
      m_out[d]  = '0;
      m_err[d]  = 1'b0;
    end
    m_cap = '0;
  endtask

  // Target-based view: a request emits SAFE cycles until SETTLE of them have been shown
  // since the latest in-range request, then the target takes over.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      int s    = (d == 0) ? int'(sel0) : int'(sel3);
      int nsrc = (d == 0) ? 4 : 3;
      bit ok   = (s < nsrc);
      if (!ok) m_err[d] = 1'b1;
      if (m_tgt[d] < 0) begin
        if (ok && s != m_act[d]) begin
          m_tgt[d] = s; m_done[d] = 1; m_out[d] = '0;
        end else begin
          m_out[d] = src_val(m_act[d]);
        end
      end else if (ok && s != m_tgt[d]) begin
        m_tgt[d] = s; m_done[d] = 1; m_out[d] = '0;
      end else if (m_done[d] < SETTLE) begin
        m_done[d]++; m_out[d] = '0;
      end else begin
        m_act[d] = m_tgt[d]; m_tgt[d] = -1; m_out[d] = src_val(m_act[d]);
      end
    end
    if (cap_en) m_cap = func;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    n_cmp++;
    if ({d_out, act, sw, err, cap} !== {19'h0, 2'd0, 1'b0, 1'b0, 19'h0}) begin
      n_bad++;
      $display("FAIL reset_state got %h/%0d/%b/%b/%h want 0/0/0/0/0", d_out, act, sw, err, cap);
    end
    n_cmp++;
    if ({d3_out, act3, sw3, err3, cap3} !== {19'h0, 2'd0, 1'b0, 1'b0, 19'h0}) begin
      n_bad++;
      $display("FAIL reset_state3 got %h/%0d/%b/%b/%h want 0/0/0/0/0",
               d3_out, act3, sw3, err3, cap3);
    end
    func  = 19'h12345;
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({d_out, act, sw} !== {19'h12345, 2'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL first_edge got %h/%0d/%b want 12345/0/0", d_out, act, sw);
    end
  endtask

  task automatic test_switch();
    ijd   = 57'({$urandom(), $urandom()});
    ijd[2*W-1 -: W] = 19'h7ABCD;
    sel0  = 2'd2;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if ({d_out, sw} !== {19'h0, 1'b1}) begin
        n_bad++;
        $display("FAIL switch_safe[%0d] got %h/%b want 0/1", i, d_out, sw);
      end
    end
    tick();
    n_cmp++;
    if ({d_out, act, sw} !== {19'h7ABCD, 2'd2, 1'b0}) begin
      n_bad++;
      $display("FAIL switch_done got %h/%0d/%b want 7abcd/2/0", d_out, act, sw);
    end
  endtask

  task automatic test_restart();
    logic [W-1:0] v3;
    v3 = 19'h5A5A5;
    ijd[3*W-1 -: W] = v3;
    ijd[1*W-1 -: W] = 19'h11111;
    sel0 = 2'd1;
    tick();
    sel0 = 2'd3;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if ({d_out, sw} !== {19'h0, 1'b1}) begin
        n_bad++;
        $display("FAIL restart_safe[%0d] got %h/%b want 0/1", i, d_out, sw);
      end
    end
    tick();
    n_cmp++;
    if ({d_out, act, sw} !== {v3, 2'd3, 1'b0}) begin
      n_bad++;
      $display("FAIL restart_done got %h/%0d/%b want %h/3/0", d_out, act, sw, v3);
    end
  endtask

  task automatic test_sel_err();
    func = 19'h2468A;
    sel3 = 2'd3;
    tick();
    n_cmp++;
    if ({err3, d3_out, act3, sw3} !== {1'b1, 19'h2468A, 2'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL sel_err_set got %b/%h/%0d/%b want 1/2468a/0/0", err3, d3_out, act3, sw3);
    end
    sel3 = 2'd1;
    tick();
    n_cmp++;
    if ({err3, sw3} !== {1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL sel_err_sticky got %b/%b want 1/1", err3, sw3);
    end
    tick();
    tick();
    n_cmp++;
    if ({err3, act3, sw, err} !== {1'b1, 2'd1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL sel_err_after got %b/%0d/%b/%b want 1/1/0/0", err3, act3, sw, err);
    end
  endtask

  task automatic test_capture();
    logic [W-1:0] f;
    sel0 = 2'd0;
    tick();
    func   = 19'h00F0F;
    cap_en = 1'b1;
    tick();
    n_cmp++;
    if ({cap, d_out, sw} !== {19'h00F0F, 19'h0, 1'b1}) begin
      n_bad++;
      $display("FAIL capture_take got %h/%h/%b want 00f0f/0/1", cap, d_out, sw);
    end
    cap_en = 1'b0;
    f      = 19'h3C3C3;
    func   = f;
    tick();
    n_cmp++;
    if ({cap, d_out, act, sw} !== {19'h00F0F, f, 2'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL capture_hold got %h/%h/%0d/%b want 00f0f/%h/0/0", cap, d_out, act, sw, f);
    end
  endtask

  task automatic test_reset_mid_settle();
    sel0 = 2'd2;
    tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({d_out, act, sw, err, cap} !== {19'h0, 2'd0, 1'b0, 1'b0, 19'h0}) begin
      n_bad++;
      $display("FAIL mid_settle_reset got %h/%0d/%b/%b/%h want 0/0/0/0/0", d_out, act, sw, err, cap);
    end
    n_cmp++;
    if ({d3_out, err3, cap3} !== {19'h0, 1'b0, 19'h0}) begin
      n_bad++;
      $display("FAIL mid_settle_reset3 got %h/%b/%h want 0/0/0", d3_out, err3, cap3);
    end
    sel0  = 2'd0;
    func  = 19'h0BEEF;
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({d_out, act, sw} !== {19'h0BEEF, 2'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL post_reset_func got %h/%0d/%b want 0beef/0/0", d_out, act, sw);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      func   = 19'($urandom());
      ijd    = 57'({$urandom(), $urandom()});
      cap_en = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) sel0 = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) sel3 = 2'($urandom_range(0, 3));
      tick();
      n_cmp++;
      if ({d_out, act, sw, err, cap} !==
          {m_out[0], 2'(m_act[0]), (m_tgt[0] >= 0), m_err[0], m_cap}) begin
        n_bad++;
        $display("FAIL random4[%0d] got %h/%0d/%b/%b/%h want %h/%0d/%b/%b/%h", i,
                 d_out, act, sw, err, cap,
                 m_out[0], m_act[0], (m_tgt[0] >= 0), m_err[0], m_cap);
      end
      n_cmp++;
      if ({d3_out, act3, sw3, err3, cap3} !==
          {m_out[1], 2'(m_act[1]), (m_tgt[1] >= 0), m_err[1], m_cap}) begin
        n_bad++;
        $display("FAIL random3[%0d] got %h/%0d/%b/%b/%h want %h/%0d/%b/%b/%h", i,
                 d3_out, act3, sw3, err3, cap3,
                 m_out[1], m_act[1], (m_tgt[1] >= 0), m_err[1], m_cap);
      end
    end
  endtask

  initial begin
    test_reset();
    test_switch();
    test_restart();
    test_sel_err();
    test_capture();
    test_reset_mid_settle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
